// File: rtl/l1d_cache_if.sv
// l1d_cache_if: core load/store port and memory/L2 port of the L1 data cache.
// The slave modport is the cache's view. The master modport is the view of the
// environment that drives core requests and answers memory requests.
interface l1d_cache_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic                             core_req_val;
  logic [ADDR_WIDTH-1:0]            core_req_addr;
  logic [1:0]                       core_req_cop;
  logic [DATA_WIDTH-1:0]            core_req_wdata;
  logic [BE_W-1:0]                  core_req_be;
  logic                             core_req_ack;
  logic [DATA_WIDTH-1:0]            core_ack_data;

  logic                             mem_req_val;
  logic [ADDR_WIDTH-1:0]            mem_req_addr;
  logic [1:0]                       mem_req_cop;
  logic [DATA_WIDTH-1:0]            mem_req_wdata;
  logic [BE_W-1:0]                  mem_req_be;
  logic                             mem_req_ack;
  logic                             mem_ack_val;
  logic [LINE_WORDS*DATA_WIDTH-1:0] mem_ack_data;

  modport slave (
    input  core_req_val, core_req_addr, core_req_cop, core_req_wdata, core_req_be,
    output core_req_ack, core_ack_data,
    output mem_req_val, mem_req_addr, mem_req_cop, mem_req_wdata, mem_req_be,
    input  mem_req_ack, mem_ack_val, mem_ack_data
  );

  modport master (
    output core_req_val, core_req_addr, core_req_cop, core_req_wdata, core_req_be,
    input  core_req_ack, core_ack_data,
    input  mem_req_val, mem_req_addr, mem_req_cop, mem_req_wdata, mem_req_be,
    output mem_req_ack, mem_ack_val, mem_ack_data
  );
endinterface

// File: rtl/l1d_cache.sv
// l1d_cache: blocking, direct-mapped L1 data cache.
// Reads allocate on a miss. Writes are write-through and do not allocate on a miss.
// Only one core request is outstanding at a time.
// A refill returns the whole line in a single memory response beat.
// Optional feature macro L1D_STATS_EN adds saturating hit and miss counters,
// stat_hit_cnt and stat_miss_cnt, which count every lookup, reads and writes alike.
// LINE_WORDS must be at least 2 so that the word-select field is non-empty.
module l1d_cache #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64
) (
  input  logic        clk,
  input  logic        rst,
  l1d_cache_if.slave  bus
`ifdef L1D_STATS_EN
  ,
  output logic [31:0] stat_hit_cnt,
  output logic [31:0] stat_miss_cnt
`endif
);
  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int BOFF_W = $clog2(BE_W);
  localparam int OFF_W  = $clog2(LINE_WORDS * BE_W);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int WSEL_W = OFF_W - BOFF_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_REFILL_REQ, S_REFILL_WAIT, S_RESP, S_WR_REQ, S_WR_RESP
  } state_t;

  state_t state_q, state_d;

  logic [SETS-1:0]       valid_q;
  logic [TAG_W-1:0]      tag_mem  [SETS];
  logic [DATA_WIDTH-1:0] data_mem [SETS][LINE_WORDS];

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            cop_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BE_W-1:0]       be_q;
  logic                  hit_q;

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [WSEL_W-1:0]     wsel;
  logic                  is_wr;
  logic                  hit;
  logic [DATA_WIDTH-1:0] rd_word;

  // Merge new write data into an existing cached word, one byte lane per enable bit.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [BE_W-1:0]       be
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_w;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

`ifdef L1D_STATS_EN
  // Increment a counter but hold it at the all-ones value instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction
`endif

  assign idx     = addr_q[OFF_W+IDX_W-1:OFF_W];
  assign tag     = addr_q[ADDR_WIDTH-1:OFF_W+IDX_W];
  assign wsel    = addr_q[OFF_W-1:BOFF_W];
  assign is_wr   = (cop_q == 2'b01);
  assign hit     = valid_q[idx] && (tag_mem[idx] == tag);
  assign rd_word = data_mem[idx][wsel];

  // State register; reset aborts whatever operation is in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and bus outputs; every output idles at zero.
  always_comb begin
    state_d            = state_q;
    bus.core_req_ack   = 1'b0;
    bus.core_ack_data  = '0;
    bus.mem_req_val    = 1'b0;
    bus.mem_req_addr   = '0;
    bus.mem_req_cop    = 2'b00;
    bus.mem_req_wdata  = '0;
    bus.mem_req_be     = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.core_req_val) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (is_wr) begin
          state_d = S_WR_REQ;
        end else if (hit) begin
          bus.core_req_ack  = 1'b1;
          bus.core_ack_data = rd_word;
          state_d           = S_IDLE;
        end else begin
          state_d = S_REFILL_REQ;
        end
      end
      S_REFILL_REQ: begin
        bus.mem_req_val  = 1'b1;
        bus.mem_req_addr = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        bus.mem_req_cop  = 2'b00;
        if (bus.mem_req_ack) state_d = S_REFILL_WAIT;
      end
      S_REFILL_WAIT: begin
        if (bus.mem_ack_val) state_d = S_RESP;
      end
      S_RESP: begin
        bus.core_req_ack  = 1'b1;
        bus.core_ack_data = rd_word;
        state_d           = S_IDLE;
      end
      S_WR_REQ: begin
        bus.mem_req_val   = 1'b1;
        bus.mem_req_addr  = addr_q;
        bus.mem_req_cop   = 2'b01;
        bus.mem_req_wdata = wdata_q;
        bus.mem_req_be    = be_q;
        if (bus.mem_req_ack) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        bus.core_req_ack = 1'b1;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the request in IDLE and remember the lookup outcome for the write merge.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && bus.core_req_val) begin
      addr_q  <= bus.core_req_addr;
      cop_q   <= bus.core_req_cop;
      wdata_q <= bus.core_req_wdata;
      be_q    <= bus.core_req_be;
    end
    if (state_q == S_LOOKUP) hit_q <= hit;
  end

  // Valid bits: cleared on reset, set when a refilled line lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (state_q == S_REFILL_WAIT && bus.mem_ack_val) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Tag and data arrays: refill overwrites the indexed line, accepted write hits merge in place.
  always_ff @(posedge clk) begin
    if (state_q == S_REFILL_WAIT && bus.mem_ack_val) begin
      tag_mem[idx] <= tag;
      for (int w = 0; w < LINE_WORDS; w++) begin
        data_mem[idx][w] <= bus.mem_ack_data[w*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (state_q == S_WR_REQ && bus.mem_req_ack && hit_q) begin
      data_mem[idx][wsel] <= merge_bytes(rd_word, wdata_q, be_q);
    end
  end

`ifdef L1D_STATS_EN
  // Lookup statistics: one count per LOOKUP cycle, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hit_cnt  <= '0;
      stat_miss_cnt <= '0;
    end else if (state_q == S_LOOKUP) begin
      if (hit) stat_hit_cnt  <= sat_inc(stat_hit_cnt);
      else     stat_miss_cnt <= sat_inc(stat_miss_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_l1d_cache.sv
// tb_l1d_cache: scoreboard bench for l1d_cache with directed vectors.
// Every refill returns the same line, with words w3..w0 = 0x44, 0x33, 0x22, 0x11.
`timescale 1ns/1ps
module tb_l1d_cache;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LW   = 4;
  localparam int SETS = 64;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  cop;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mreq_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l1d_cache_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) bus ();

`ifdef L1D_STATS_EN
  logic [31:0] stat_hit_cnt, stat_miss_cnt;
`endif

  l1d_cache #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW), .SETS(SETS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef L1D_STATS_EN
    ,
    .stat_hit_cnt  (stat_hit_cnt),
    .stat_miss_cnt (stat_miss_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] core_exp_q [$];
  mreq_t       mem_exp_q  [$];

  int ack_delay = 0;
  bit hold_line = 1'b0;
  int late_req  = 0;
  bit bp_en     = 1'b0;
  int bp_hi     = 0;
  int bp_unstable = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: acks after ack_delay cycles and returns the line on the following cycle.
  initial begin
    int cnt;
    int late_done;
    bit pend;
    cnt = 0;
    late_done = 0;
    pend = 1'b0;
    bus.mem_req_ack  = 1'b0;
    bus.mem_ack_val  = 1'b0;
    bus.mem_ack_data = {32'h44, 32'h33, 32'h22, 32'h11};
    forever begin
      @(posedge clk);
      #1;
      bus.mem_req_ack = 1'b0;
      bus.mem_ack_val = 1'b0;
      if (late_req != late_done) begin
        bus.mem_ack_val = 1'b1;
        late_done++;
      end else if (pend) begin
        bus.mem_ack_val = 1'b1;
        pend = 1'b0;
      end else if (bus.mem_req_val && !rst) begin
        if (cnt < ack_delay) begin
          cnt++;
        end else begin
          bus.mem_req_ack = 1'b1;
          cnt = 0;
          pend = (bus.mem_req_cop == 2'b00) && !hold_line;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT acks the core or a memory transfer happens.
  initial begin
    mreq_t e;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      if (bus.core_req_ack) begin
        if (core_exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_core_ack: got ack data 0x%0h, required no ack", bus.core_ack_data);
        end else begin
          d = core_exp_q.pop_front();
          check("core_ack_data", bus.core_ack_data, d);
        end
      end
      if (bus.mem_req_val && bus.mem_req_ack) begin
        if (mem_exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_mem_req: got addr 0x%0h cop %0d, required no request",
                   bus.mem_req_addr, bus.mem_req_cop);
        end else begin
          e = mem_exp_q.pop_front();
          check("mem_req_addr", bus.mem_req_addr, e.addr);
          check("mem_req_cop", bus.mem_req_cop, e.cop);
          if (e.cop == 2'b01) begin
            check("mem_req_wdata", bus.mem_req_wdata, e.wdata);
            check("mem_req_be", bus.mem_req_be, e.be);
          end
        end
      end
    end
  end

  // Backpressure observer: counts mem_req_val cycles and any change of addr/cop while held.
  initial begin
    logic [31:0] a0;
    logic [1:0]  c0;
    forever begin
      @(negedge clk);
      if (bp_en && bus.mem_req_val) begin
        if (bp_hi == 0) begin
          a0 = bus.mem_req_addr;
          c0 = bus.mem_req_cop;
        end else if (bus.mem_req_addr !== a0 || bus.mem_req_cop !== c0) begin
          bp_unstable++;
        end
        bp_hi++;
      end
    end
  end

  task automatic core_req(input logic [31:0] a, input logic [1:0] cop, input logic [31:0] wd,
                          input logic [3:0] be, output int lat, output bit saw_mem);
    lat = 0;
    saw_mem = 1'b0;
    bus.core_req_addr  = a;
    bus.core_req_cop   = cop;
    bus.core_req_wdata = wd;
    bus.core_req_be    = be;
    bus.core_req_val   = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (bus.mem_req_val) saw_mem = 1'b1;
    end while (!bus.core_req_ack && lat < 200);
    if (!bus.core_req_ack) begin
      checks++;
      failures++;
      $display("FAIL core_ack_timeout: got no ack for addr 0x%0h after %0d cycles, required ack", a, lat);
    end
    @(posedge clk);
    #1;
    bus.core_req_val = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] cop, input logic [31:0] exp,
                    input bit refill, output int lat, output bit saw_mem);
    mreq_t e;
    if (refill) begin
      e.addr = a & 32'hFFFF_FFF0;
      e.cop = 2'b00;
      e.wdata = 32'h0;
      e.be = 4'h0;
      mem_exp_q.push_back(e);
    end
    core_exp_q.push_back(exp);
    core_req(a, cop, 32'h0, 4'h0, lat, saw_mem);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    mreq_t e;
    int lat;
    bit sm;
    e.addr = a;
    e.cop = 2'b01;
    e.wdata = wd;
    e.be = be;
    mem_exp_q.push_back(e);
    core_exp_q.push_back(32'h0);
    core_req(a, 2'b01, wd, be, lat, sm);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    bit sm;
    int n;
    mreq_t e;
    bus.core_req_val   = 1'b0;
    bus.core_req_addr  = '0;
    bus.core_req_cop   = 2'b00;
    bus.core_req_wdata = '0;
    bus.core_req_be    = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_core_req_ack", bus.core_req_ack, 1'b0);
    check("reset_core_ack_data", bus.core_ack_data, 32'h0);
    check("reset_mem_req_val", bus.mem_req_val, 1'b0);
    check("reset_mem_req_addr", bus.mem_req_addr, 32'h0);
`ifdef L1D_STATS_EN
    check("reset_stat_hit", stat_hit_cnt, 32'h0);
    check("reset_stat_miss", stat_miss_cnt, 32'h0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Cold miss then hit in the same line
    rd(32'h104, 2'b00, 32'h22, 1'b1, lat, sm);
    rd(32'h108, 2'b00, 32'h33, 1'b0, lat, sm);
    check("hit_latency", lat, 2);
    check("hit_no_mem_req", sm, 1'b0);
`ifdef L1D_STATS_EN
    check("stat_hit_after_s1", stat_hit_cnt, 32'd1);
    check("stat_miss_after_s1", stat_miss_cnt, 32'd1);
`endif

    // Unknown op code behaves as a read (hit)
    rd(32'h10C, 2'b11, 32'h44, 1'b0, lat, sm);
    check("cop11_no_mem_req", sm, 1'b0);

    // Write hit merges low two bytes
    wr(32'h104, 32'hAABB_CCDD, 4'b0011);
    rd(32'h104, 2'b00, 32'h0000_CCDD, 1'b0, lat, sm);
    check("merged_hit_latency", lat, 2);

    // Write miss does not allocate
    wr(32'h2000, 32'h1234_5678, 4'b1111);
    rd(32'h2000, 2'b00, 32'h11, 1'b1, lat, sm);

    // Conflict eviction on index 0x10
    rd(32'h104, 2'b00, 32'h0000_CCDD, 1'b0, lat, sm);
    rd(32'h504, 2'b00, 32'h22, 1'b1, lat, sm);
    rd(32'h104, 2'b00, 32'h22, 1'b1, lat, sm);

    // Backpressure: five cycles without ack, then one transfer
    ack_delay = 5;
    bp_en = 1'b1;
    rd(32'h904, 2'b00, 32'h22, 1'b1, lat, sm);
    bp_en = 1'b0;
    ack_delay = 0;
    check("bp_val_cycles", bp_hi, 6);
    check("bp_unstable", bp_unstable, 0);

    // Reset while waiting for refill data
    hold_line = 1'b1;
    e.addr = 32'h100;
    e.cop = 2'b00;
    e.wdata = 32'h0;
    e.be = 4'h0;
    mem_exp_q.push_back(e);
    bus.core_req_addr = 32'h104;
    bus.core_req_cop  = 2'b00;
    bus.core_req_val  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.mem_req_val && bus.mem_req_ack) && n < 50);
    check("abort_refill_issued", (n < 50), 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.core_req_val = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_mem_req_val", bus.mem_req_val, 1'b0);
    check("abort_core_req_ack", bus.core_req_ack, 1'b0);
    late_req++;
    repeat (3) @(posedge clk);
    #1;
    hold_line = 1'b0;
    rd(32'h104, 2'b00, 32'h22, 1'b1, lat, sm);
    check("post_reset_refilled", sm, 1'b1);
`ifdef L1D_STATS_EN
    check("stat_hit_after_reset", stat_hit_cnt, 32'd0);
    check("stat_miss_after_reset", stat_miss_cnt, 32'd1);
`endif

    repeat (5) @(posedge clk);
    check("core_queue_drained", core_exp_q.size(), 0);
    check("mem_queue_drained", mem_exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/l1d_cache.md
Name: l1d_cache

Overview:
- Parametrised, blocking, direct-mapped L1 data cache that fills the L1D slot between the core load/store port and the memory/L2 port.
- Read policy: allocate on read miss.
- Write policy: write-through, no-write-allocate.
- One outstanding core request at a time. Full-line refill from memory in a single response beat.

Parameters:
- ADDR_WIDTH, 32, core/memory byte address width.
- DATA_WIDTH, 32, core data word width; multiple of 8.
- LINE_WORDS, 4, words per line; power of 2.
- SETS, 64, number of lines; power of 2.
- Derived: BE_W=DATA_WIDTH/8; OFF_W=log2(LINE_WORDS*BE_W); IDX_W=log2(SETS); TAG_W=ADDR_WIDTH-IDX_W-OFF_W; WSEL=addr[OFF_W-1:log2(BE_W)].

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- core_req_val  in  1  core request valid; held with all fields stable until core_req_ack
- core_req_addr  in  ADDR_WIDTH  byte address
- core_req_cop  in  2  operation: 2'b00 read, 2'b01 write; other codes are treated as read
- core_req_wdata  in  DATA_WIDTH  write data
- core_req_be  in  BE_W  write byte enables
- core_req_ack  out  1  single-cycle completion pulse
- core_ack_data  out  DATA_WIDTH  read data; valid only while core_req_ack=1 for a read
- mem_req_val  out  1  memory request valid
- mem_req_addr  out  ADDR_WIDTH  line-aligned for refill; core address for write
- mem_req_cop  out  2  2'b00 line read, 2'b01 word write
- mem_req_wdata  out  DATA_WIDTH  write data
- mem_req_be  out  BE_W  write byte enables
- mem_req_ack  in  1  memory accepted the request
- mem_ack_val  in  1  refill data valid
- mem_ack_data  in  LINE_WORDS*DATA_WIDTH  refill line; word 0 in the LSBs

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; all valid bits cleared.
  - Tag and data storage are not reset.
  - Reset asserted in any state aborts the operation. The following cycle has mem_req_val=0 and core_req_ack=0.
- Storage: valid bit vector held in flops; tag and data arrays indexed by addr[OFF_W+IDX_W-1:OFF_W].
- State IDLE: if core_req_val, register addr/cop/wdata/be and go to LOOKUP.
- State LOOKUP: hit = valid[idx] && tag[idx]==addr tag.
  - Read hit: core_req_ack=1, core_ack_data=word WSEL; go to IDLE. Hit latency is ack 2 cycles after core_req_val rises.
  - Read miss: go to REFILL_REQ.
  - Write (hit or miss): go to WR_REQ.
- State REFILL_REQ:
  - Drive mem_req_val=1, mem_req_addr=addr with the low OFF_W bits zeroed, mem_req_cop=00.
  - Hold all mem_req_* stable until mem_req_ack, then go to REFILL_WAIT.
  - If mem_req_ack is already high in the first REFILL_REQ cycle, the transfer completes that cycle.
- State REFILL_WAIT:
  - On mem_ack_val: write the line, set tag, set valid; go to RESP.
  - mem_ack_val in any other state is ignored.
- State RESP: core_req_ack=1, core_ack_data=word WSEL of the new line; go to IDLE.
- State WR_REQ:
  - Drive mem_req_val=1, mem_req_addr=core addr, cop=01, wdata, be; hold until mem_req_ack.
  - On mem_req_ack, if the LOOKUP hit was recorded, merge wdata into the cached word per byte enable.
  - Go to WR_RESP. Write misses never allocate.
- State WR_RESP: core_req_ack=1; core_ack_data=0; go to IDLE.
- core_req_ack is never asserted in IDLE or LOOKUP-miss cycles.
- A new request can be sampled in the IDLE cycle immediately after the ack.
- mem_req_val is deasserted the cycle after mem_req_ack.
- Direct-mapped replacement: a refill unconditionally overwrites the indexed line. There are no dirty lines, so nothing is written back.
- Back-to-back requests to the same line after a refill are hits.

Optional Feature:
- Macro L1D_STATS_EN.
- When defined:
  - Adds outputs stat_hit_cnt[31:0] and stat_miss_cnt[31:0].
  - Each counter increments once per LOOKUP hit or miss (reads and writes both count).
  - Counters saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
All scenarios use default parameters; mem_ack_data words are w3..w0 = 0x44,0x33,0x22,0x11.
- Cold read miss then hit:
  - Read 0x104 -> mem_req addr 0x100, cop 00; return the line -> core_ack_data=0x22.
  - Then read 0x108 -> ack 2 cycles after val, data 0x33, mem_req_val stays 0.
- Write hit merge: after the fill, write 0x104 data 0xAABBCCDD be 4'b0011 -> mem_req addr 0x104 cop 01 be 0011; read 0x104 hits and returns 0x0000CCDD.
- Write miss no-allocate: write 0x2000 -> memory write only; following read 0x2000 issues a refill for 0x2000.
- Conflict eviction: read 0x104, then 0x504 (same index 0x10) -> refill 0x500; re-read 0x104 misses again.
- Backpressure: hold mem_req_ack=0 for 5 cycles in REFILL_REQ -> mem_req_val/addr/cop stable all 5 cycles; single transfer on ack.
- Reset mid-refill: assert rst in REFILL_WAIT -> next cycle mem_req_val=0, core_req_ack=0; a late mem_ack_val is ignored; read 0x104 then misses. With L1D_STATS_EN, scenario 1 ends with hit_cnt=1, miss_cnt=1.
